// File: rtl/mux_arb_nx1.sv
// -----------------------------------------------------------------------------
// mux_arb_nx1
//
// N-to-1 data selector with one registered output stage and valid/ready
// handshaking on every input channel and on the output.
//
//   MODE 0 : the channel is chosen by the binary select i_control.
//   MODE 1 : round-robin arbitration among the valid channels; i_control is
//            ignored.
//
// The output register accepts a new word when it is empty or is being
// drained in the same cycle. This gives one word per cycle of throughput and
// one cycle of latency from input transfer to o_valid.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_data     packed input channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_valid    per-channel valid
//   o_ready    per-channel ready (combinational, at most one bit set)
//   i_control  channel select (MODE 0 only)
//   o_data     registered output word
//   o_valid    output word valid
//   i_ready    downstream ready
//   o_sel      index of the channel that supplied o_data
//   o_sel_err  registered flag: last cycle's i_control was out of range (MODE 0)
// -----------------------------------------------------------------------------
module mux_arb_nx1 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 5,
  parameter int SEL_WIDTH  = 3,
  parameter int MODE       = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            o_ready,
  input  logic [SEL_WIDTH-1:0]             i_control,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [SEL_WIDTH-1:0]             o_sel,
  output logic                             o_sel_err
);

  // One extra bit so that NUM_INPUTS itself is representable even when it is
  // an exact power of two (e.g. 16 channels with a 4-bit select).
  localparam logic [SEL_WIDTH:0]   NUM_IN_EXT = (SEL_WIDTH+1)'(NUM_INPUTS);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(NUM_INPUTS - 1);
  localparam logic [SEL_WIDTH-1:0] ONE_IDX    = SEL_WIDTH'(1);

  // Round-robin pointer: the channel with highest priority in the next
  // arbitration. Only moves in MODE 1 on an accepted transfer.
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  ptr_next;

  logic                  load_en;
  logic                  ctrl_in_range;
  logic                  rr_found;
  logic [SEL_WIDTH-1:0]  rr_idx;
  logic                  grant_exists;
  logic [SEL_WIDTH-1:0]  grant;
  logic                  grant_valid;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  accept_ok;
  logic                  xfer_in;
  logic                  xfer_out;

  assign load_en       = !o_valid || i_ready;
  assign ctrl_in_range = {1'b0, i_control} < NUM_IN_EXT;

  // Round-robin search in two passes: first the channels at or above the
  // pointer, then (only if none of those is valid) the lowest valid channel
  // overall, which by then must lie below the pointer. This is equivalent to
  // the circular search ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!rr_found && i_valid[i] && (SEL_WIDTH'(i) >= ptr)) begin
        rr_found = 1'b1;
        rr_idx   = SEL_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!rr_found && i_valid[i]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_WIDTH'(i);
      end
    end
  end

  // Grant source depends on the mode. In MODE 0 a grant exists whenever the
  // select is in range, independent of that channel's valid, so o_ready can
  // be offered before the source raises valid.
  always_comb begin
    grant_exists = 1'b0;
    grant        = '0;
    if (MODE == 0) begin
      grant_exists = ctrl_in_range;
      grant        = i_control;
    end else begin
      grant_exists = rr_found;
      grant        = rr_idx;
    end
  end

  assign accept_ok = !i_rst && load_en && grant_exists;

  // Per-channel decode. The data mux is an explicit equality compare per
  // channel so that a non-granted channel (including one carrying X) never
  // reaches grant_data; it also avoids indexing past the last channel when
  // the select is wider than needed.
  always_comb begin
    o_ready     = '0;
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant == SEL_WIDTH'(k)) begin
        grant_valid = i_valid[k];
        grant_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_ready[k]  = accept_ok;
      end
    end
  end

  assign xfer_in  = accept_ok && grant_valid;
  assign xfer_out = o_valid && i_ready;

  // Pointer moves to the channel just after the winner, wrapping at the end.
  assign ptr_next = (grant == LAST_IDX) ? '0 : grant + ONE_IDX;

  // Output register, error flag and round-robin pointer. A simultaneous
  // drain and load keeps o_valid high and simply replaces the word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_sel     <= '0;
      o_sel_err <= 1'b0;
      ptr       <= '0;
    end else begin
      o_sel_err <= (MODE == 0) && !ctrl_in_range;
      if (xfer_in) begin
        o_data  <= grant_data;
        o_sel   <= grant;
        o_valid <= 1'b1;
      end else if (xfer_out) begin
        o_valid <= 1'b0;
      end
      if (xfer_in && (MODE == 1)) begin
        ptr <= ptr_next;
      end
    end
  end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
Parametrised N-to-1 data selector with a registered output stage and valid/ready handshaking on every input and on the output. It replaces fixed-width combinational select muxes wherever a source may stall or a sink may back-pressure, such as the writeback/result-source path and shared memory-port sharing. Two modes are available: MODE 0 steers by an explicit binary select, and MODE 1 arbitrates round-robin among requesting channels.

Parameters:
DATA_WIDTH, 32, width of each data channel.
NUM_INPUTS, 5, number of input channels; legal range 1..16.
SEL_WIDTH, 3, width of i_control and o_sel; must be >= max(1, ceil(log2(NUM_INPUTS))).
MODE, 0, 0 = explicit select via i_control; 1 = round-robin arbitration with i_control ignored.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_data  in  NUM_INPUTS*DATA_WIDTH  packed channels; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
i_valid  in  NUM_INPUTS  per-channel valid.
o_ready  out  NUM_INPUTS  per-channel ready; combinational.
i_control  in  SEL_WIDTH  channel select, used in MODE 0 only.
o_data  out  DATA_WIDTH  registered output data.
o_valid  out  1  output data valid.
i_ready  in  1  downstream ready.
o_sel  out  SEL_WIDTH  index of the channel that supplied the current o_data.
o_sel_err  out  1  registered flag; 1 when, on the previous cycle, MODE 0 had i_control >= NUM_INPUTS.

Behaviour:
- Reset (i_rst=1 at a clock edge): o_data=0, o_valid=0, o_sel=0, o_sel_err=0, round-robin pointer ptr=0. While i_rst=1, o_ready is all 0. Any word held at reset is discarded.
- Load enable is defined as load_en = !o_valid | i_ready, so the output register accepts a word when it is empty or is being drained in the same cycle.
- Grant in MODE 0: g = i_control when i_control < NUM_INPUTS. Otherwise there is no grant, and all o_ready = 0.
- Grant in MODE 1: g = the first k with i_valid[k]=1, searching ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1. If no channel is valid there is no grant.
- o_ready[k] = load_en & grant_exists & (g==k). At most one bit of o_ready is high.
- Input transfer happens when i_valid[g] & o_ready[g]. On the next edge: o_data <= channel g, o_sel <= g, o_valid <= 1.
  - MODE 1 only: ptr <= (g==NUM_INPUTS-1) ? 0 : g+1.
- Output transfer happens when o_valid & i_ready. If no input transfers in the same cycle, o_valid <= 0. o_data and o_sel hold their last values.
- Drain and load in the same cycle: the new word replaces the old one and o_valid stays 1. This gives full throughput of one word per cycle.
- Stall (o_valid=1, i_ready=0): o_data, o_sel and o_valid hold; all o_ready = 0; ptr holds.
- Latency: one cycle from input transfer to o_valid.
- ptr advances only on an accepted transfer. Idle cycles and stalls never move it.
- o_sel_err <= (MODE==0) & (i_control >= NUM_INPUTS), registered every cycle regardless of handshake. In MODE 1 it is constant 0.
- NUM_INPUTS=1: the design degenerates to a one-stage pipeline register. ptr stays 0 and o_sel stays 0.
- Unused i_data bits of non-granted channels have no effect. X on a non-granted channel must not propagate to o_data.

Test Plan:
- Reset/idle, MODE 0, i_control=2, i_valid=0, i_ready=1 → o_valid=0, o_data=0, o_sel_err=0. Apply i_rst for 1 cycle while o_valid=1 → next cycle o_valid=0, o_data=0.
- MODE 0 select: ch1=0x11111111, ch3=0x33333333, both valid, i_control=3 → one cycle later o_data=0x33333333, o_sel=3, o_valid=1; o_ready=5'b01000 on the accept cycle.
- MODE 0 out of range, NUM_INPUTS=5: i_control=6 with all channels valid → o_ready=0, o_valid stays 0, o_sel_err=1 the following cycle. Then i_control=0 → o_sel_err returns to 0 one cycle later.
- Back-pressure: hold i_ready=0 for 3 cycles after a word is loaded → o_data, o_sel and o_valid are unchanged and o_ready=0. Release i_ready=1 while ch0 is valid → back-to-back transfer with o_valid held at 1 and the new data on the next cycle.
- MODE 1 fairness: all 5 channels valid continuously, i_ready=1 → o_sel sequence 0,1,2,3,4,0,1.
  - Then only ch2 and ch4 valid with ptr=3 → grant order 4,2,4,2.
- MODE 1 wrap and idle: single request on ch4, then all i_valid=0 for 2 cycles, then ch0 and ch4 valid → ptr=0 after the wrap, so ch0 is granted first, then ch4.
